// File: rtl/image_conv_pkg.sv
// Shared types and frame geometry for the halftone image converter,
// its scheduler and the bench.
package image_conv_pkg;

    localparam int ROWS    = 6;
    localparam int ROW_W   = 8;
    localparam int FRAME_W = ROWS * ROW_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        START   = 3'd2,
        BUSY    = 3'd3,
        RESPOND = 3'd4,
        ABORT   = 3'd5
    } conv_state_e;

    // Index width that stays legal when there is only one slot.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after rr_ptr, wrapping to the
// lowest set request when nothing at or above the pointer is pending.
module rr_arbiter
    import image_conv_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] pick,
    output logic [PTR_W-1:0] pick_idx,
    output logic             pick_vld
);

    logic [PTR_W-1:0] w_hi_idx;
    logic [PTR_W-1:0] w_any_idx;
    logic             w_hi_vld;

    // NOTE: every output and temporary gets a default first, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_hi_idx  = '0;
        w_any_idx = '0;
        w_hi_vld  = 1'b0;
        pick_vld  = 1'b0;
        // Walk downward so the last hit is the lowest index in each class.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_vld  = 1'b1;
                w_any_idx = PTR_W'(i);
                if (PTR_W'(i) >= rr_ptr) begin
                    w_hi_vld = 1'b1;
                    w_hi_idx = PTR_W'(i);
                end
            end
        end
        pick_idx = w_hi_vld ? w_hi_idx : w_any_idx;
        pick     = pick_vld ? (N_REQ'(1) << pick_idx) : '0;
    end

endmodule

// File: rtl/image_conv_scheduler.sv
// Time-shares one halftone converter between N_REQ frame sources:
// clear, go, wait for done (with timeout), capture the frame, ack the owner.
module image_conv_scheduler
    import image_conv_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   grant,
    output logic [N_REQ-1:0]   ack,
    output logic               err,
    output logic [FRAME_W-1:0] htpv_frame,
    output logic               busy,
    output logic               conv_clr,
    output logic               conv_go,
    input  logic               conv_done,
    input  logic [FRAME_W-1:0] conv_htpv
);

    localparam int PTR_W = idx_width(N_REQ);
    localparam int CLR_W = idx_width(CLR_CYCLES);

    localparam logic [CLR_W-1:0] CLR_LAST  = CLR_W'(CLR_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0] OWNER_TOP = PTR_W'(N_REQ - 1);

    conv_state_e        r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [CLR_W-1:0]   r_clr_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [N_REQ-1:0]   r_grant;
    logic [N_REQ-1:0]   r_ack;
    logic               r_err;
    logic [FRAME_W-1:0] r_frame;
    logic               r_busy;
    logic               r_conv_clr;
    logic               r_conv_go;

    logic [N_REQ-1:0]   w_pick;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_vld;
    logic               w_owner_req;
    logic               w_abort;
    logic [PTR_W-1:0]   w_next_ptr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req      (req),
        .rr_ptr   (r_rr_ptr),
        .pick     (w_pick),
        .pick_idx (w_pick_idx),
        .pick_vld (w_pick_vld)
    );

    assign w_owner_req = req[r_owner];
    assign w_next_ptr  = (r_owner == OWNER_TOP) ? '0 : r_owner + PTR_W'(1);

    // The owner may withdraw any time before the result is in hand.
    assign w_abort = !w_owner_req &&
                     (r_state == CLEAR || r_state == START || r_state == BUSY);

    // NOTE: all state and output registers use non-blocking assignments, so
    // every decision below reads the values from before this clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_clr_cnt  <= '0;
            r_to_cnt   <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_frame    <= '0;
            r_busy     <= 1'b0;
            r_conv_clr <= 1'b0;
            r_conv_go  <= 1'b0;
        end else begin
            r_ack <= '0;
            if (w_abort) begin
                r_state    <= ABORT;
                r_conv_clr <= 1'b1;
                r_conv_go  <= 1'b0;
                r_clr_cnt  <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_pick_vld) begin
                            r_grant    <= w_pick;
                            r_owner    <= w_pick_idx;
                            r_clr_cnt  <= '0;
                            r_conv_clr <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= CLEAR;
                        end
                    end
                    CLEAR: begin
                        if (r_clr_cnt == CLR_LAST) begin
                            r_conv_clr <= 1'b0;
                            r_conv_go  <= 1'b1;
                            r_state    <= START;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + CLR_W'(1);
                        end
                    end
                    START: begin
                        r_conv_go <= 1'b0;
                        r_to_cnt  <= '0;
                        r_state   <= BUSY;
                    end
                    BUSY: begin
                        // Done is checked first so it wins on the timeout cycle.
                        if (conv_done) begin
                            r_frame <= conv_htpv;
                            r_err   <= 1'b0;
                            r_ack   <= r_grant;
                            r_state <= RESPOND;
                        end else if (r_to_cnt == TO_LAST) begin
                            r_frame <= '0;
                            r_err   <= 1'b1;
                            r_ack   <= r_grant;
                            r_state <= RESPOND;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
                    RESPOND: begin
                        r_err    <= 1'b0;
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                    ABORT: begin
                        if (r_clr_cnt == CLR_LAST) begin
                            r_conv_clr <= 1'b0;
                            r_grant    <= '0;
                            r_rr_ptr   <= w_next_ptr;
                            r_busy     <= 1'b0;
                            r_state    <= IDLE;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + CLR_W'(1);
                        end
                    end
                    default: begin
                        r_grant    <= '0;
                        r_busy     <= 1'b0;
                        r_conv_clr <= 1'b0;
                        r_conv_go  <= 1'b0;
                        r_state    <= IDLE;
                    end
                endcase
            end
        end
    end

    assign grant      = r_grant;
    assign ack        = r_ack;
    assign err        = r_err;
    assign htpv_frame = r_frame;
    assign busy       = r_busy;
    assign conv_clr   = r_conv_clr;
    assign conv_go    = r_conv_go;

endmodule
